r_i_decode_pipe: RTL and testbench

- Next-generation instruction decoder for the badmips core.
- Decodes R-type (OP=0, by func) and I-type ALU instructions (by OP) into ALU control, write-enable, destination register and immediate.
- All outputs are registered behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput and a registered in_ready.
- Sits between instruction fetch and register-read/ALU; adds an illegal-instruction flag and a saturating illegal counter.

---
 rtl/r_i_decode_pipe.sv | 145 ++++++++++++++
 tb/tb_r_i_decode_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/r_i_decode_pipe.sv
// r_i_decode_pipe: badmips R/I-type ALU decoder with registered outputs and a 2-entry skid buffer
// Ports:
//   i_clk, i_rst_n (async active-low), i_flush (sync drop of buffered entries)
//   i_in_valid / o_in_ready / i_instr       : instruction input handshake
//   o_out_valid / i_out_ready               : decoded output handshake
//   o_alu_op, o_we, o_alu_src_imm, o_wr_addr, o_imm, o_illegal : decoded entry
//   o_illegal_cnt                           : saturating count of delivered illegal entries
module r_i_decode_pipe #(
    parameter int ALU_W        = 3,
    parameter int ENABLE_ITYPE = 1,
    parameter int CNT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ALU_W-1:0] o_alu_op,
    output logic             o_we,
    output logic             o_alu_src_imm,
    output logic [4:0]       o_wr_addr,
    output logic [31:0]      o_imm,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);
    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             we;
        logic             src_imm;
        logic [4:0]       wr_addr;
        logic [31:0]      imm;
        logic             illegal;
    } entry_t;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [2:0] w_code;
    logic       w_legal;
    logic       w_sext;
    logic       w_itype;
    logic       w_unused;
    entry_t     w_dec;
    entry_t     r_out;
    entry_t     r_skid;
    logic       r_out_valid;
    logic       r_skid_valid;
    logic       r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    logic       w_acc;
    logic       w_free;

    assign w_op     = i_instr[31:26];
    assign w_fn     = i_instr[5:0];
    assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

    always_comb begin
        w_code  = 3'b000;
        w_legal = 1'b0;
        w_sext  = 1'b0;
        if (w_op == 6'b000000) begin
            w_legal = 1'b1;
            case (w_fn)
                6'b100000: w_code = 3'b100;
                6'b100010: w_code = 3'b101;
                6'b100100: w_code = 3'b000;
                6'b100101: w_code = 3'b001;
                6'b100110: w_code = 3'b010;
                6'b100111: w_code = 3'b011;
                6'b101011: w_code = 3'b110;
                6'b000100: w_code = 3'b111;
                default:   w_legal = 1'b0;
            endcase
        end else if (ENABLE_ITYPE != 0) begin
            w_legal = 1'b1;
            case (w_op)
                6'b001000: begin w_code = 3'b100; w_sext = 1'b1; end
                6'b001011: begin w_code = 3'b110; w_sext = 1'b1; end
                6'b001100: w_code = 3'b000;
                6'b001101: w_code = 3'b001;
                6'b001110: w_code = 3'b010;
                default:   w_legal = 1'b0;
            endcase
        end
    end

    // Illegal words leave w_code at zero, so every field below collapses to zero
    assign w_itype         = w_legal & (w_op != 6'b000000);
    assign w_dec.alu_op    = ALU_W'(w_code);
    assign w_dec.wr_addr   = !w_legal ? 5'd0 : w_itype ? i_instr[20:16] : i_instr[15:11];
    assign w_dec.we        = w_legal & (w_dec.wr_addr != 5'd0);
    assign w_dec.src_imm   = w_itype;
    assign w_dec.imm       = !w_itype ? 32'd0 : w_sext ? {{16{i_instr[15]}}, i_instr[15:0]} : {16'd0, i_instr[15:0]};
    assign w_dec.illegal   = !w_legal;

    assign w_acc  = i_in_valid & r_in_ready;
    assign w_free = !r_out_valid | i_out_ready;

    // The skid can only hold an entry while in_ready is low, so when the output
    // drains the skid no new accept can coincide with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_free) begin
            r_out_valid  <= r_skid_valid | w_acc;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            if (r_skid_valid)
                r_out <= r_skid;
            else if (w_acc)
                r_out <= w_dec;
        end else if (w_acc) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (r_out_valid & i_out_ready & r_out.illegal & (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_alu_op      = r_out.alu_op;
    assign o_we          = r_out.we;
    assign o_alu_src_imm = r_out.src_imm;
    assign o_wr_addr     = r_out.wr_addr;
    assign o_imm         = r_out.imm;
    assign o_illegal     = r_out.illegal;
    assign o_illegal_cnt = r_cnt;
endmodule

// File: tb/tb_r_i_decode_pipe.sv
// tb_r_i_decode_pipe: directed self-checking bench for r_i_decode_pipe
module tb_r_i_decode_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_we, a_src, a_ill;
    logic [2:0]  a_alu;
    logic [4:0]  a_wr;
    logic [31:0] a_imm;
    logic [1:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_we, b_src, b_ill;
    logic [2:0]  b_alu;
    logic [4:0]  b_wr;
    logic [31:0] b_imm;
    logic [7:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    r_i_decode_pipe #(.ALU_W(3), .ENABLE_ITYPE(1), .CNT_W(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(a_in_ready), .i_instr(instr), .o_out_valid(a_out_valid),
        .i_out_ready(out_ready), .o_alu_op(a_alu), .o_we(a_we), .o_alu_src_imm(a_src),
        .o_wr_addr(a_wr), .o_imm(a_imm), .o_illegal(a_ill), .o_illegal_cnt(a_cnt));

    r_i_decode_pipe #(.ALU_W(3), .ENABLE_ITYPE(0), .CNT_W(8)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(b_in_ready), .i_instr(instr), .o_out_valid(b_out_valid),
        .i_out_ready(out_ready), .o_alu_op(b_alu), .o_we(b_we), .o_alu_src_imm(b_src),
        .o_wr_addr(b_wr), .o_imm(b_imm), .o_illegal(b_ill), .o_illegal_cnt(b_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_valid", 32'(a_out_valid), 0);
        chk("rst_ready", 32'(a_in_ready), 1);
        chk("rst_alu", 32'(a_alu), 0);
        chk("rst_we", 32'(a_we), 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        rst_n = 1'b1;
        cyc();

        // add $3,$1,$2
        in_valid = 1'b1; instr = 32'h00221820;
        cyc();
        chk("add_valid", 32'(a_out_valid), 1);
        chk("add_alu", 32'(a_alu), 3'b100);
        chk("add_we", 32'(a_we), 1);
        chk("add_wr", 32'(a_wr), 3);
        chk("add_src", 32'(a_src), 0);
        chk("add_ill", 32'(a_ill), 0);

        // addi then ori back-to-back
        instr = 32'h2005FFFF;
        cyc();
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_alu", 32'(a_alu), 3'b100);
        chk("addi_wr", 32'(a_wr), 5);
        chk("addi_src", 32'(a_src), 1);
        instr = 32'h34068000;
        cyc();
        chk("ori_imm", a_imm, 32'h00008000);
        chk("ori_alu", 32'(a_alu), 3'b001);
        chk("ori_wr", 32'(a_wr), 6);
        chk("ori_src", 32'(a_src), 1);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", 32'(a_out_valid), 0);

        // stall with sub/and/or
        in_valid = 1'b1; instr = 32'h00221822; out_ready = 1'b0;
        cyc();
        chk("sub_alu", 32'(a_alu), 3'b101);
        chk("sub_ready", 32'(a_in_ready), 1);
        instr = 32'h00221824;
        cyc();
        chk("stall_ready", 32'(a_in_ready), 0);
        chk("stall_alu", 32'(a_alu), 3'b101);
        instr = 32'h00221825;
        cyc();
        chk("hold_ready", 32'(a_in_ready), 0);
        chk("hold_alu", 32'(a_alu), 3'b101);
        chk("hold_valid", 32'(a_out_valid), 1);
        out_ready = 1'b1;
        cyc();
        chk("and_alu", 32'(a_alu), 3'b000);
        chk("and_ready", 32'(a_in_ready), 1);
        cyc();
        chk("or_alu", 32'(a_alu), 3'b001);
        chk("or_valid", 32'(a_out_valid), 1);
        in_valid = 1'b0;
        cyc();
        chk("or_drain", 32'(a_out_valid), 0);

        // illegal stream and counter saturation (CNT_W=2)
        in_valid = 1'b1; instr = 32'h0000003F;
        cyc();
        chk("ill_flag", 32'(a_ill), 1);
        chk("ill_we", 32'(a_we), 0);
        chk("ill_alu", 32'(a_alu), 0);
        chk("ill_cnt0", 32'(a_cnt), 0);
        cyc();
        chk("ill_cnt1", 32'(a_cnt), 1);
        cyc();
        chk("ill_cnt2", 32'(a_cnt), 2);
        cyc();
        chk("ill_cnt3", 32'(a_cnt), 3);
        in_valid = 1'b0;
        cyc();
        chk("ill_sat", 32'(a_cnt), 3);
        chk("ill_drain", 32'(a_out_valid), 0);

        // $0 destination, and I-type disabled instance
        in_valid = 1'b1; instr = 32'h00220020;
        cyc();
        chk("r0_alu", 32'(a_alu), 3'b100);
        chk("r0_we", 32'(a_we), 0);
        chk("r0_ill", 32'(a_ill), 0);
        instr = 32'h2005FFFF;
        cyc();
        chk("noi_ill", 32'(b_ill), 1);
        chk("noi_we", 32'(b_we), 0);
        chk("noi_imm", b_imm, 0);
        chk("noi_wr", 32'(b_wr), 0);
        chk("a_addi_ill", 32'(a_ill), 0);
        in_valid = 1'b0;
        cyc();
        // b illegals delivered: addi, ori, 4x 0x3F, addi
        chk("b_cnt", 32'(b_cnt), 7);

        // illegal transfer during flush still counts
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        chk("fx_cnt", 32'(b_cnt), 8);
        chk("fx_valid", 32'(b_out_valid), 0);
        flush = 1'b0;

        // fill output + skid then flush
        in_valid = 1'b1; instr = 32'h00221820; out_ready = 1'b0;
        cyc(); cyc();
        chk("fill_valid", 32'(a_out_valid), 1);
        chk("fill_ready", 32'(a_in_ready), 0);
        flush = 1'b1;
        cyc();
        chk("fl_valid", 32'(a_out_valid), 0);
        chk("fl_ready", 32'(a_in_ready), 1);
        chk("fl_cnt", 32'(a_cnt), 3);
        cyc();
        chk("fl_drop", 32'(a_out_valid), 0);
        flush = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("post_fl_valid", 32'(a_out_valid), 1);
        chk("post_fl_alu", 32'(a_alu), 3'b100);

        // fill then async reset mid-stall
        out_ready = 1'b0; instr = 32'h2005FFFF;
        cyc(); cyc();
        chk("fill2_ready", 32'(a_in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(a_out_valid), 0);
        chk("ar_ready", 32'(a_in_ready), 1);
        chk("ar_alu", 32'(a_alu), 0);
        chk("ar_we", 32'(a_we), 0);
        chk("ar_src", 32'(a_src), 0);
        chk("ar_wr", 32'(a_wr), 0);
        chk("ar_imm", a_imm, 0);
        chk("ar_ill", 32'(a_ill), 0);
        chk("ar_cnt", 32'(a_cnt), 0);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h00221820;
        cyc();
        chk("pr_valid", 32'(a_out_valid), 1);
        chk("pr_alu", 32'(a_alu), 3'b100);
        chk("pr_wr", 32'(a_wr), 3);
        in_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
